rho_word_framer: RTL and testbench
==================================

// Module: rho_word_framer
// PURPOSE
//  Host-side framer for the 32-bit rho datapath. Feeds one 128-bit block as four 32-bit pdi words.
//  Drives the per-byte decrypt mask and the shift strobe, and applies Romulus padding to a short final block.
//  Collects the returned pdo words and emits them to the host on a valid/ready stream.
//  Sits between the host data FIFO and the state-update shift register; the top controller owns blk_ack.
// PARAMETERS
//  none
// PORTS
//  clk        in  1   clock, all logic rising-edge
//  rst        in  1   asynchronous, active-low reset
//  bdi        in  32  host data word; byte 0 of word in [31:24]
//  bdi_size   in  3   valid bytes in bdi, 1..4, MSB lanes first
//  bdi_last   in  1   bdi is last word of message
//  bdi_valid  in  1   host word available
//  bdi_ready  out 1   host word accepted when bdi_valid&bdi_ready
//  dec_mode   in  1   1 = decryption, sampled per word
//  out_en     in  1   0 = absorb only (AD), no bdo produced
//  pad_only   in  1   one-cycle pulse in FEED, wcnt=0: build an all-pad block (len 0)
//  pdi        out 32  word to state update
//  decrypt    out 4   per-lane select, bit i covers pdi[8i+7:8i]
//  se         out 1   shift strobe: state update consumes pdi this cycle
//  pdo        in  32  combinational rho output for the current pdi
//  blk_full   out 1   four words shifted; block awaits the permutation
//  blk_pad    out 1   the held block was padded (valid while blk_full)
//  blk_ack    in  1   controller done with block; return to FEED
//  bdo        out 32  output word; unused lanes are zero
//  bdo_size   out 3   valid bytes in bdo
//  bdo_last   out 1   bdo carries the last message byte
//  bdo_valid  out 1   output word valid
//  bdo_ready  in  1   host accepts bdo
// BEHAVIOUR
//  Reset values:
//   - state=FEED, wcnt=0, bcnt=0, output buffer empty.
//   - All outputs 0: bdi_ready, se, pdi, decrypt, blk_full, blk_pad, bdo*.
//  FSM states: FEED, PAD, HOLD.
//  FEED:
//   - ofree = output buffer empty, or draining this cycle.
//   - bdi_ready = ofree.
//   - On accept: se=1, pdi=bdi with lanes beyond bdi_size replaced by pad, wcnt++, bcnt += bdi_size.
//   - decrypt[lane] = dec_mode & lane is real data; pad lanes are always 0.
//  Word classification:
//   - bdi_size<4 is treated as last, whatever bdi_last says.
//   - A last word with wcnt<3 -> PAD.
//   - A word at wcnt=3 -> HOLD.
//  Pad rule (bcnt counted after the final word):
//   - Bytes after the data are 0x00.
//   - Block byte 15 (word3[7:0]) = bcnt, 0..15.
//   - Exactly 16 data bytes: no padding, blk_pad=0; otherwise blk_pad=1.
//  PAD:
//   - Emits one zero/pad word per cycle with se=1, decrypt=0, no output write, until wcnt=3 is shifted.
//   - Then -> HOLD.
//  pad_only: FEED -> PAD with bcnt=0, so word3 = 0x00000000; the input word, if any, is not accepted.
//  HOLD:
//   - blk_full=1, bdi_ready=0, se=0.
//   - On blk_ack: -> FEED, wcnt=0, bcnt=0, blk_full=0 next cycle.
//   - blk_ack outside HOLD is ignored.
//  Output:
//   - On each accepted data word with out_en=1, buffer captures {pdo masked to bdi_size, size, last}.
//   - bdo_valid=1 from the next cycle; latency 1.
//   - bdo holds stable until bdo_valid&bdo_ready.
//  Simultaneous events:
//   - Capture and drain in the same cycle are legal (throughput 1 word/cycle).
//   - blk_ack with a pending bdo: FSM advances, buffer unaffected.
//  Wrap: wcnt is 2 bits and wraps only via HOLD->FEED; bcnt saturates at 16.
//  Async reset mid-block: everything cleared at once, partial block discarded, no bdo emitted afterwards.
// CONFIGURATION
//  RHO_OUTBUF2_EN:
//   - Defined: output buffer is a 2-entry FIFO, ofree = fewer than 2 entries.
//     Host stalls of one cycle do not stall input.
//   - Undefined: single register as described above.
//  bdo ordering and reset behaviour are identical in both builds.
// TESTING
//  T1 enc, 4 words size 4, last on 4th, pdo=0x11111111:
//     se on 4 cycles, decrypt=0, blk_full, blk_pad=0, four bdo size 4, bdo_last on 4th.
//  T2 enc, words size 4, then size 1 last 0xAB000000:
//     pdi = 0xAB000000, then 0x00000000, then 0x00000005; blk_pad=1; bdo sizes 4 then 1.
//  T3 dec, 2 words size 4 + size 2 last:
//     decrypt = F, F, C, 0; bdo from pdo lanes with lanes outside bdo_size zeroed; no bdo for the pad word.
//  T4 bdo_ready low 3 cycles mid-block:
//     bdi_ready drops within 1 cycle (2 with RHO_OUTBUF2_EN); no word lost or duplicated.
//  T5 pad_only, then blk_ack:
//     4 se pulses, pdi all zero, blk_pad=1, no bdo; FEED after ack.
//  T6 rst low during wcnt=2:
//     all outputs 0 asynchronously; next block starts at wcnt=0 with no stale bdo.

Source files
------------

// File: rtl/rho_word_framer.sv
`default_nettype none
// ============================================================================
//  Module   : rho_word_framer
//  Purpose  : Host-side framer for the 32-bit rho datapath. Feeds a 128-bit
//             block to the state-update shift register as four pdi words,
//             drives the per-lane decrypt mask and the shift strobe, applies
//             Romulus padding to a short final block and returns the pdo
//             words to the host on a valid/ready stream.
//  Config   : RHO_OUTBUF2_EN - when defined, the output buffer is a 2-entry
//             FIFO so one-cycle host stalls do not back-pressure the input.
//             When undefined, a single output register is used.
//  Revision : 1.0 - initial release
// ============================================================================
module rho_word_framer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bdi,
  input  logic [2:0]  bdi_size,
  input  logic        bdi_last,
  input  logic        bdi_valid,
  output logic        bdi_ready,
  input  logic        dec_mode,
  input  logic        out_en,
  input  logic        pad_only,
  output logic [31:0] pdi,
  output logic [3:0]  decrypt,
  output logic        se,
  input  logic [31:0] pdo,
  output logic        blk_full,
  output logic        blk_pad,
  input  logic        blk_ack,
  output logic [31:0] bdo,
  output logic [2:0]  bdo_size,
  output logic        bdo_last,
  output logic        bdo_valid,
  input  logic        bdo_ready
);

  typedef enum logic [1:0] {
    ST_FEED = 2'd0,
    ST_PAD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [4:0] C_FULL_BYTES = 5'd16;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_wcnt;
  logic [1:0]  w_wcnt_nxt;
  logic [4:0]  r_bcnt;
  logic [4:0]  w_bcnt_nxt;
  logic        r_pad;
  logic        w_pad_nxt;
  logic        r_live;

  logic [2:0]  w_sz;
  logic [3:0]  w_lmask;
  logic [31:0] w_bmask;
  logic        w_short;
  logic        w_last;
  logic [5:0]  w_bsum;
  logic [4:0]  w_bcnt_acc;
  logic        w_po;
  logic        w_take;
  logic        w_accept;
  logic        w_cap;
  logic        w_ofree;

  // Decode the byte count into an effective size and an MSB-first lane mask.
  always_comb begin
    w_sz    = 3'd4;
    w_lmask = 4'b1111;
    case (bdi_size)
      3'd1: begin w_sz = 3'd1; w_lmask = 4'b1000; end
      3'd2: begin w_sz = 3'd2; w_lmask = 4'b1100; end
      3'd3: begin w_sz = 3'd3; w_lmask = 4'b1110; end
      default: ;
    endcase
  end

  assign w_bmask    = {{8{w_lmask[3]}}, {8{w_lmask[2]}}, {8{w_lmask[1]}}, {8{w_lmask[0]}}};
  // A short word can only ever be the end of the message.
  assign w_short    = (w_sz != 3'd4);
  assign w_last     = bdi_last | w_short;
  assign w_bsum     = {1'b0, r_bcnt} + {3'b000, w_sz};
  assign w_bcnt_acc = (w_bsum > 6'd16) ? C_FULL_BYTES : w_bsum[4:0];
  // pad_only is only meaningful at the start of a block.
  assign w_po       = pad_only & (r_wcnt == 2'd0);
  // r_live keeps bdi_ready low while reset is asserted and for the first edge.
  assign w_take     = bdi_valid & w_ofree & r_live & ~w_po;
  assign w_cap      = w_accept & out_en;

  // Reset-qualified enable so the combinational ready is 0 during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

  // Framer state, word counter, byte counter and pad flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FEED;
      r_wcnt  <= 2'd0;
      r_bcnt  <= 5'd0;
      r_pad   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_pad   <= w_pad_nxt;
    end
  end

  // Next-state logic plus the shift-side outputs (pdi, decrypt, se, ready).
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_bcnt_nxt  = r_bcnt;
    w_pad_nxt   = r_pad;
    w_accept    = 1'b0;
    bdi_ready   = 1'b0;
    se          = 1'b0;
    pdi         = 32'h0;
    decrypt     = 4'h0;
    case (r_state)
      ST_FEED: begin
        bdi_ready = w_ofree & r_live & ~w_po;
        if (w_po) begin
          // All-pad block of length zero: word3 carries bcnt = 0.
          w_state_nxt = ST_PAD;
          w_bcnt_nxt  = 5'd0;
          w_pad_nxt   = 1'b1;
        end else if (w_take) begin
          w_accept   = 1'b1;
          se         = 1'b1;
          decrypt    = {4{dec_mode}} & w_lmask;
          // Pad lanes are zero; a short word in the last slot carries the
          // length byte in its lowest lane, which is never a data lane.
          pdi        = (bdi & w_bmask) |
                       (((r_wcnt == 2'd3) && w_short) ? {27'h0, w_bcnt_acc} : 32'h0);
          w_wcnt_nxt = r_wcnt + 2'd1;
          w_bcnt_nxt = w_bcnt_acc;
          if (r_wcnt == 2'd3) begin
            w_state_nxt = ST_HOLD;
            w_pad_nxt   = w_short;
          end else if (w_last) begin
            w_state_nxt = ST_PAD;
            w_pad_nxt   = 1'b1;
          end
        end
      end
      ST_PAD: begin
        se         = 1'b1;
        pdi        = (r_wcnt == 2'd3) ? {27'h0, r_bcnt} : 32'h0;
        w_wcnt_nxt = r_wcnt + 2'd1;
        if (r_wcnt == 2'd3) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (blk_ack) begin
          w_state_nxt = ST_FEED;
          w_wcnt_nxt  = 2'd0;
          w_bcnt_nxt  = 5'd0;
          w_pad_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_FEED;
      end
    endcase
  end

  assign blk_full = (r_state == ST_HOLD);
  assign blk_pad  = (r_state == ST_HOLD) & r_pad;

`ifdef RHO_OUTBUF2_EN
  logic [31:0] r_fd [2];
  logic [2:0]  r_fs [2];
  logic [1:0]  r_fl;
  logic        r_wp;
  logic        r_rp;
  logic [1:0]  r_cnt;
  logic        w_drain;

  assign w_drain = (r_cnt != 2'd0) & bdo_ready;
  assign w_ofree = (r_cnt != 2'd2);

  // Two-entry output FIFO; capture and drain may coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fd[0] <= 32'h0;
      r_fd[1] <= 32'h0;
      r_fs[0] <= 3'd0;
      r_fs[1] <= 3'd0;
      r_fl    <= 2'b00;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      if (w_cap) begin
        r_fd[r_wp] <= pdo & w_bmask;
        r_fs[r_wp] <= w_sz;
        r_fl[r_wp] <= w_last;
        r_wp       <= ~r_wp;
      end
      if (w_drain) begin
        r_rp <= ~r_rp;
      end
      case ({w_cap, w_drain})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bdo_valid = (r_cnt != 2'd0);
  assign bdo       = bdo_valid ? r_fd[r_rp] : 32'h0;
  assign bdo_size  = bdo_valid ? r_fs[r_rp] : 3'd0;
  assign bdo_last  = bdo_valid & r_fl[r_rp];
`else
  logic        r_bv;
  logic [31:0] r_bdo;
  logic [2:0]  r_bsz;
  logic        r_blast;

  // The register is free when empty or when its word leaves this cycle.
  assign w_ofree = ~r_bv | bdo_ready;

  // Single output register; a new capture overrides the drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bv    <= 1'b0;
      r_bdo   <= 32'h0;
      r_bsz   <= 3'd0;
      r_blast <= 1'b0;
    end else if (w_cap) begin
      r_bv    <= 1'b1;
      r_bdo   <= pdo & w_bmask;
      r_bsz   <= w_sz;
      r_blast <= w_last;
    end else if (r_bv & bdo_ready) begin
      r_bv    <= 1'b0;
    end
  end

  assign bdo_valid = r_bv;
  assign bdo       = r_bv ? r_bdo : 32'h0;
  assign bdo_size  = r_bv ? r_bsz : 3'd0;
  assign bdo_last  = r_bv & r_blast;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rho_word_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rho_word_framer
//  Purpose  : Self-checking bench for rho_word_framer. Each block is modelled
//             as a 16-byte array built from the message bytes and the
//             Romulus pad rule; expected pdi/decrypt words and bdo words are
//             queued and compared against what the framer produces.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rho_word_framer;

  localparam logic [31:0] C_K = 32'hC3A5_5A3C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bdi = 32'h0;
  logic [2:0]  bdi_size = 3'd4;
  logic        bdi_last = 1'b0;
  logic        bdi_valid = 1'b0;
  logic        bdi_ready;
  logic        dec_mode = 1'b0;
  logic        out_en = 1'b1;
  logic        pad_only = 1'b0;
  logic [31:0] pdi;
  logic [3:0]  decrypt;
  logic        se;
  logic [31:0] pdo;
  logic        blk_full;
  logic        blk_pad;
  logic        blk_ack = 1'b0;
  logic [31:0] bdo;
  logic [2:0]  bdo_size;
  logic        bdo_last;
  logic        bdo_valid;
  logic        bdo_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int rdy_mode = 0;

  logic [31:0] q_pdi [$];
  logic [3:0]  q_dec [$];
  logic [35:0] q_bdo [$];
  logic [35:0] mon_e;

  // Stand-in for the rho function: any fixed combinational map of pdi.
  assign pdo = pdi ^ C_K;

  rho_word_framer u_dut (
    .clk(clk), .rst(rst),
    .bdi(bdi), .bdi_size(bdi_size), .bdi_last(bdi_last),
    .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
    .dec_mode(dec_mode), .out_en(out_en), .pad_only(pad_only),
    .pdi(pdi), .decrypt(decrypt), .se(se), .pdo(pdo),
    .blk_full(blk_full), .blk_pad(blk_pad), .blk_ack(blk_ack),
    .bdo(bdo), .bdo_size(bdo_size), .bdo_last(bdo_last),
    .bdo_valid(bdo_valid), .bdo_ready(bdo_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bytemask(input int sz);
    logic [31:0] m = 32'h0;
    for (int b = 0; b < sz; b++) m[31-8*b -: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [3:0] lanemask(input int sz);
    logic [3:0] m = 4'h0;
    for (int b = 0; b < sz; b++) m[3-b] = 1'b1;
    return m;
  endfunction

  // Host readiness: random, forced low, or forced high.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bdo_ready = ($urandom_range(0, 3) != 0);
      1:       bdo_ready = 1'b0;
      default: bdo_ready = 1'b1;
    endcase
  end

  // Compare every shifted word and every drained bdo word against the model.
  always @(negedge clk) begin
    if (rst) begin
      if (se) begin
        if (q_pdi.size() == 0) chk("se_unexp", 64'(se), 64'(0));
        else begin
          chk("pdi", 64'(pdi), 64'(q_pdi.pop_front()));
          chk("decrypt", 64'(decrypt), 64'(q_dec.pop_front()));
        end
      end
      if (bdo_valid && bdo_ready) begin
        if (q_bdo.size() == 0) chk("bdo_unexp", 64'(bdo_valid), 64'(0));
        else begin
          mon_e = q_bdo.pop_front();
          chk("bdo", 64'(bdo), 64'(mon_e[31:0]));
          chk("bdo_size", 64'(bdo_size), 64'(mon_e[34:32]));
          chk("bdo_last", 64'(bdo_last), 64'(mon_e[35]));
        end
      end
    end
  end

  // Present one word and hold it until accepted; returns at posedge+1.
  task automatic send_word(input logic [31:0] d, input int sz, input bit last,
                           input bit dec, input bit oen);
    int to = 0;
    bdi = d; bdi_size = 3'(sz); bdi_last = last;
    dec_mode = dec; out_en = oen; bdi_valid = 1'b1;
    @(negedge clk);
    while (!bdi_ready && to < 200) begin
      to++;
      @(negedge clk);
    end
    if (to >= 200) chk("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    bdi_valid = 1'b0;
    bdi = $urandom;
    bdi_size = 3'($urandom_range(1, 4));
    bdi_last = 1'($urandom_range(0, 1));
  endtask

  // Model one block, drive it, check the held block, then acknowledge it.
  task automatic run_block(input int nw, input int lastsz, input bit lastflag,
                           input bit dec, input bit oen, input bit po);
    logic [7:0]  blk [16];
    logic [31:0] wd [4];
    int          szs [4];
    int          total = 0;
    int          to = 0;
    logic [35:0] e;
    for (int i = 0; i < 16; i++) blk[i] = 8'h00;
    for (int w = 0; w < nw; w++) begin
      szs[w] = (w == nw - 1) ? lastsz : 4;
      wd[w]  = $urandom;
      for (int b = 0; b < szs[w]; b++) blk[4*w+b] = wd[w][31-8*b -: 8];
      total += szs[w];
    end
    if (total < 16) blk[15] = 8'(total);
    for (int i = 0; i < 4; i++) begin
      q_pdi.push_back({blk[4*i], blk[4*i+1], blk[4*i+2], blk[4*i+3]});
      q_dec.push_back((i < nw && dec) ? lanemask(szs[i]) : 4'h0);
    end
    if (oen) begin
      for (int w = 0; w < nw; w++) begin
        e = {1'((w == nw - 1) && (lastflag || szs[w] < 4)), 3'(szs[w]),
             (wd[w] ^ C_K) & bytemask(szs[w])};
        q_bdo.push_back(e);
      end
    end
    if (po) begin
      bdi = $urandom; bdi_size = 3'd4; bdi_valid = 1'b1; pad_only = 1'b1;
      @(negedge clk);
      chk("po_bdi_ready", 64'(bdi_ready), 64'(0));
      @(posedge clk); #1;
      pad_only = 1'b0; bdi_valid = 1'b0;
    end else begin
      for (int w = 0; w < nw; w++) begin
        blk_ack = ($urandom_range(0, 3) == 0);
        send_word(wd[w], szs[w], (w == nw - 1) ? lastflag : 1'b0, dec, oen);
        blk_ack = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    while (!blk_full && to < 60) begin
      to++;
      @(negedge clk);
    end
    chk("blk_full", 64'(blk_full), 64'(1));
    chk("blk_pad", 64'(blk_pad), 64'(total != 16));
    chk("hold_ready", 64'(bdi_ready), 64'(0));
    chk("pdi_left", 64'(q_pdi.size()), 64'(0));
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    blk_ack = 1'b1;
    @(posedge clk); #1;
    blk_ack = 1'b0;
    @(negedge clk);
    chk("ack_full", 64'(blk_full), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int to;
    logic [31:0] w0, w1;
    int nw, ls;
    bit lf;

    // Reset state
    #2;
    chk("rst_ready", 64'(bdi_ready), 64'(0));
    chk("rst_se", 64'(se), 64'(0));
    chk("rst_pdi", 64'(pdi), 64'(0));
    chk("rst_full", 64'({blk_full, blk_pad}), 64'(0));
    chk("rst_bdo", 64'({bdo_valid, bdo_last, bdo_size, bdo}), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // T1: four full encryption words, last on the fourth
    run_block(4, 4, 1'b1, 1'b0, 1'b1, 1'b0);
    // T2: full word then a 1-byte last word
    run_block(2, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    // T3: decryption, two full words then a 2-byte last word
    run_block(3, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    // Short final word in the fourth slot carries its own length byte
    run_block(4, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    // T4: host stalls for three cycles mid-block
    fork
      run_block(4, 4, 1'b1, 1'b0, 1'b1, 1'b0);
      begin
        repeat (2) @(posedge clk);
        rdy_mode = 1;
        repeat (3) @(negedge clk);
`ifndef RHO_OUTBUF2_EN
        if (bdo_valid) chk("t4_stall", 64'(bdi_ready), 64'(0));
`endif
        rdy_mode = 0;
      end
    join
    // T5: all-pad block
    run_block(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    // Absorb-only block produces no bdo
    run_block(3, 4, 1'b1, 1'b1, 1'b0, 1'b0);

    // T6: asynchronous reset with wcnt=2 and a bdo word pending
    w0 = $urandom; w1 = $urandom;
    q_pdi.push_back(w0); q_dec.push_back(4'h0);
    q_pdi.push_back(w1); q_dec.push_back(4'h0);
    q_bdo.push_back({1'b0, 3'd4, w0 ^ C_K});
    q_bdo.push_back({1'b0, 3'd4, w1 ^ C_K});
    send_word(w0, 4, 1'b0, 1'b0, 1'b1);
    send_word(w1, 4, 1'b0, 1'b0, 1'b1);
    rdy_mode = 1; bdo_ready = 1'b0;
    chk("t6_pending", 64'(bdo_valid), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("t6_ready", 64'(bdi_ready), 64'(0));
    chk("t6_se_pdi", 64'({se, decrypt, pdi}), 64'(0));
    chk("t6_full", 64'({blk_full, blk_pad}), 64'(0));
    chk("t6_bdo", 64'({bdo_valid, bdo_last, bdo_size, bdo}), 64'(0));
    q_pdi.delete(); q_dec.delete(); q_bdo.delete();
    @(posedge clk); #1;
    rst = 1'b1; rdy_mode = 0;
    @(posedge clk); #1;
    run_block(4, 4, 1'b1, 1'b1, 1'b1, 1'b0);

    // Randomized blocks
    for (int k = 0; k < 40; k++) begin
      nw = $urandom_range(1, 4);
      ls = $urandom_range(1, 4);
      lf = (nw < 4 && ls == 4) ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        run_block(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      else
        run_block(nw, ls, lf, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), 1'b0);
    end

    // Drain remaining output words
    rdy_mode = 2;
    to = 0;
    while (q_bdo.size() != 0 && to < 100) begin
      to++;
      @(posedge clk);
    end
    repeat (5) @(posedge clk);
    chk("bdo_left", 64'(q_bdo.size()), 64'(0));
    chk("end_valid", 64'(bdo_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
